// File: rtl/mem_access.sv
// mem_access: MEM-stage controller driving MEM/WB and a req/ack data bus for loads and stores.
// Inputs : clk, resetn (async active-low), ex_* fields from EX/MEM, dbus_ack/dbus_rdata from the bus.
// Outputs: dbus_req/we/addr/wdata to the bus, mem_stall to earlier stages, mem_* to MEM/WB, mem_err.
// Optional: define MEM_TIMEOUT_EN to abort a REQ after TIMEOUT_CYCLES cycles without ack (sets mem_err).
module mem_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_alu_out,
  input  logic [63:0]       ex_hilo_out,
  input  logic [2:0]        ex_rf_wsel,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_rdata2,
  input  logic              ex_ram_we,
  input  logic              ex_rf_nwe,
  input  logic              ex_is_ram,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic              mem_stall,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_result,
  output logic [63:0]       mem_hilo_out,
  output logic [2:0]        mem_rf_wsel,
  output logic [4:0]        mem_rd,
  output logic              mem_rf_nwe,
  output logic              mem_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0] pc_q, pc_d, result_q, result_d;
  logic [63:0] hilo_q, hilo_d;
  logic [2:0] wsel_q, wsel_d;
  logic [4:0] rd_q, rd_d;
  logic nwe_q, nwe_d;
  logic wb, done, aborted;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, abort_q, abort_d;
  assign aborted = abort_q;
  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign aborted = 1'b0;
  assign mem_err = 1'b0;
`endif
  // MEM/WB takes the EX/MEM fields either for a non-memory op in IDLE or when an access finishes;
  // every other cycle it is loaded with a bubble.
  assign done = state_q == DONE;
  assign wb   = done || (state_q == IDLE && !ex_is_ram);
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    pc_d     = wb ? ex_pc : '0;
    hilo_d   = wb ? ex_hilo_out : '0;
    wsel_d   = wb ? ex_rf_wsel : '0;
    rd_d     = wb ? ex_rd : '0;
    result_d = !wb ? '0 : (done && !we_q) ? buf_q : ex_alu_out;
    nwe_d    = wb && ex_rf_nwe && !(done && (we_q || aborted));
    dbus_req  = 1'b0;
    mem_stall = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
    abort_d = abort_q;
`endif
    case (state_q)
      IDLE: begin
        mem_stall = ex_is_ram;
        if (ex_is_ram) begin
          we_d    = ex_ram_we;
          addr_d  = {ex_alu_out[ADDR_W-1:2], 2'b00};
          wdata_d = ex_rdata2;
          state_d = REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          abort_d = 1'b0;
`endif
        end
      end
      REQ: begin
        dbus_req  = 1'b1;
        mem_stall = 1'b1;
        if (dbus_ack) begin
          buf_d   = dbus_rdata;
          state_d = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Aborted access: the load buffer is zeroed so the bubble-free writeback carries 0.
          buf_d   = '0;
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      pc_q     <= '0;
      result_q <= '0;
      hilo_q   <= '0;
      wsel_q   <= '0;
      rd_q     <= '0;
      nwe_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      hilo_q   <= hilo_d;
      wsel_q   <= wsel_d;
      rd_q     <= rd_d;
      nwe_q    <= nwe_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
`endif
    end
  end
  assign dbus_we      = we_q;
  assign dbus_addr    = addr_q;
  assign dbus_wdata   = wdata_q;
  assign mem_pc       = pc_q;
  assign mem_result   = result_q;
  assign mem_hilo_out = hilo_q;
  assign mem_rf_wsel  = wsel_q;
  assign mem_rd       = rd_q;
  assign mem_rf_nwe   = nwe_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven and randomized checks of mem_access against a transaction-level model.
module tb_mem_access;
  logic clk = 1'b0;
  logic resetn;
  logic [31:0] ex_pc, ex_alu_out, ex_rdata2, dbus_wdata, dbus_rdata, mem_pc, mem_result;
  logic [63:0] ex_hilo_out, mem_hilo_out;
  logic [2:0] ex_rf_wsel, mem_rf_wsel;
  logic [4:0] ex_rd, mem_rd;
  logic ex_ram_we, ex_rf_nwe, ex_is_ram, dbus_req, dbus_we, dbus_ack, mem_stall, mem_rf_nwe, mem_err;
  logic [31:0] dbus_addr;
  always #5 clk = ~clk;
  mem_access #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .ex_pc(ex_pc), .ex_alu_out(ex_alu_out), .ex_hilo_out(ex_hilo_out),
    .ex_rf_wsel(ex_rf_wsel), .ex_rd(ex_rd), .ex_rdata2(ex_rdata2), .ex_ram_we(ex_ram_we),
    .ex_rf_nwe(ex_rf_nwe), .ex_is_ram(ex_is_ram), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .mem_pc(mem_pc), .mem_result(mem_result), .mem_hilo_out(mem_hilo_out),
    .mem_rf_wsel(mem_rf_wsel), .mem_rd(mem_rd), .mem_rf_nwe(mem_rf_nwe), .mem_err(mem_err)
  );
  typedef struct {
    logic is_ram, we, nwe, e_nwe;
    logic [31:0] pc, alu, wd, rdata, e_res, e_addr;
    logic [4:0] rd;
    int dly;
  } vec_t;
  int errors = 0, checks = 0, req_pulses = 0, exp_pulses = 0;
  logic req_prev = 1'b0, exp_err = 1'b0;
  always @(negedge clk) begin
    if (dbus_req && !req_prev) req_pulses++;
    req_prev <= dbus_req;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic is_ram, input logic we, input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] wd, input logic [4:0] rd, input logic nwe, input int dly,
                              input logic [31:0] rdata, input logic [31:0] e_res, input logic [31:0] e_addr,
                              input logic e_nwe);
    vec_t v;
    v.is_ram = is_ram; v.we = we; v.pc = pc; v.alu = alu; v.wd = wd; v.rd = rd; v.nwe = nwe;
    v.dly = dly; v.rdata = rdata; v.e_res = e_res; v.e_addr = e_addr; v.e_nwe = e_nwe;
    return v;
  endfunction
  // Reference model: what the instruction must write back and which word it must address.
  function automatic vec_t model(input vec_t v);
    v.e_res  = !v.is_ram ? v.alu : v.we ? v.alu : v.rdata;
    v.e_nwe  = v.is_ram && v.we ? 1'b0 : v.nwe;
    v.e_addr = v.alu - (v.alu % 4);
    return v;
  endfunction
  task automatic drive(input vec_t v);
    ex_pc = v.pc; ex_alu_out = v.alu; ex_hilo_out = {~v.alu, v.pc}; ex_rf_wsel = v.rd[2:0];
    ex_rd = v.rd; ex_rdata2 = v.wd; ex_ram_we = v.we; ex_rf_nwe = v.nwe; ex_is_ram = v.is_ram;
    dbus_ack = 1'b0;
  endtask
  task automatic check_wb(input vec_t v);
    chk("wb_pc", mem_pc, v.pc);
    chk("wb_result", mem_result, v.e_res);
    chk("wb_hilo", mem_hilo_out, {~v.alu, v.pc});
    chk("wb_wsel", mem_rf_wsel, v.rd[2:0]);
    chk("wb_rd", mem_rd, v.rd);
    chk("wb_nwe", mem_rf_nwe, v.e_nwe);
    chk("wb_err", mem_err, exp_err);
  endtask
  task automatic check_bubble(input string tag);
    chk({tag, "_bubble_nwe"}, mem_rf_nwe, 0);
    chk({tag, "_bubble_res"}, mem_result, 0);
    chk({tag, "_bubble_pc"}, mem_pc, 0);
  endtask
  // Runs one instruction starting just after a rising edge; returns just after its writeback edge.
  task automatic run(input vec_t v);
    drive(v);
    if (!v.is_ram) begin
      dbus_ack = 1'($urandom_range(0, 1));
      dbus_rdata = $urandom;
      @(negedge clk);
      chk("pt_stall", mem_stall, 0);
      chk("pt_req", dbus_req, 0);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end else begin
      exp_pulses++;
      @(negedge clk);
      chk("idle_stall", mem_stall, 1);
      chk("idle_req", dbus_req, 0);
      @(posedge clk); #1;
      for (int i = 1; i <= v.dly; i++) begin
        if (i == v.dly) begin dbus_ack = 1'b1; dbus_rdata = v.rdata; end
        else dbus_rdata = $urandom;
        @(negedge clk);
        chk("req_req", dbus_req, 1);
        chk("req_stall", mem_stall, 1);
        chk("req_we", dbus_we, v.we);
        chk("req_addr", dbus_addr, v.e_addr);
        chk("req_wdata", dbus_wdata, v.wd);
        check_bubble("req");
        @(posedge clk); #1;
        dbus_ack = 1'b0;
      end
      @(negedge clk);
      chk("done_req", dbus_req, 0);
      chk("done_stall", mem_stall, 0);
      check_bubble("done");
      @(posedge clk); #1;
    end
    check_wb(v);
  endtask
  vec_t tbl[5];
  vec_t v;
  initial begin
    tbl[0] = mk(0, 0, 32'h100, 32'h1234, 32'h0, 5'd5, 1, 0, 32'h0, 32'h1234, 32'h1234, 1);
    tbl[1] = mk(1, 0, 32'h104, 32'h1003, 32'h0, 5'd7, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h1000, 1);
    tbl[2] = mk(1, 1, 32'h108, 32'h2008, 32'hA5A5A5A5, 5'd9, 1, 1, 32'h0, 32'h2008, 32'h2008, 0);
    tbl[3] = mk(1, 0, 32'h10C, 32'h300E, 32'h0, 5'd3, 1, 2, 32'h12345678, 32'h12345678, 32'h300C, 1);
    tbl[4] = mk(1, 1, 32'h110, 32'h4001, 32'h5A5A0F0F, 5'd4, 1, 1, 32'h0, 32'h4001, 32'h4000, 0);
    v = tbl[0];
    drive(v);
    ex_is_ram = 1'b0; dbus_rdata = '0; resetn = 1'b0;
    #12;
    chk("rst_req", dbus_req, 0);
    chk("rst_addr", dbus_addr, 0);
    chk("rst_result", mem_result, 0);
    chk("rst_nwe", mem_rf_nwe, 0);
    chk("rst_err", mem_err, 0);
    #4 resetn = 1'b1;
    for (int i = 0; i < 5; i++) run(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      v.is_ram = 1'($urandom_range(0, 1)); v.we = 1'($urandom_range(0, 1));
      v.nwe = 1'($urandom_range(0, 1)); v.pc = $urandom; v.alu = $urandom; v.wd = $urandom;
      v.rd = 5'($urandom); v.dly = $urandom_range(1, 4); v.rdata = $urandom;
      run(model(v));
    end
`ifdef MEM_TIMEOUT_EN
    v = model(mk(1, 0, 32'h200, 32'h5004, 32'h0, 5'd6, 1, 0, 32'h0, 32'h0, 32'h0, 0));
    v.e_res = 32'h0; v.e_nwe = 1'b0;
    drive(v);
    exp_pulses++;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_req", dbus_req, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_req_low", dbus_req, 0);
    chk("to_err", mem_err, 1);
    @(posedge clk); #1;
    exp_err = 1'b1;
    check_wb(v);
    run(tbl[0]);
`endif
    v = tbl[1];
    drive(v);
    exp_pulses++;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_req_pre", dbus_req, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_req", dbus_req, 0);
    chk("mid_we", dbus_we, 0);
    chk("mid_addr", dbus_addr, 0);
    chk("mid_wdata", dbus_wdata, 0);
    chk("mid_result", mem_result, 0);
    chk("mid_pc", mem_pc, 0);
    chk("mid_err", mem_err, 0);
    exp_err = 1'b0;
    ex_is_ram = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    run(tbl[1]);
    run(tbl[2]);
    @(negedge clk);
    chk("req_pulses", req_pulses, exp_pulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
